// File: rtl/sar_result_fifo_if.sv
// Handshake bundle between the SAR converter, the result FIFO and the
// digital back end. The FIFO uses the slave modport; the driving side
// (converter + consumer) uses the master modport.
interface sar_result_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] sar_in;
    logic              eoc;
    logic              clr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [FILL_W-1:0] fill;
    logic              overflow;

    modport master (
        output sar_in, eoc, clr, dout_ready,
        input  dout, dout_valid, fill, overflow
    );

    modport slave (
        input  sar_in, eoc, clr, dout_ready,
        output dout, dout_valid, fill, overflow
    );
endinterface

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: captures SAR codes on the rising edge of eoc, optionally
// averages blocks of 2^AVG_LOG2 codes, and queues results in a circular
// FIFO drained through a valid/ready port. Sticky overflow flags dropped
// results.
//
// Build option: define SAR_AVG_EN to compile in the block-averaging path.
// Without it every captured code is pushed unmodified and AVG_LOG2 is unused.
module sar_result_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input logic               clk,
    input logic               rst_n,
    sar_result_fifo_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    // Elaboration-time parameter sanity checks.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sar_result_fifo: DEPTH must be a power of two >= 2");
        end
        if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg
            $error("sar_result_fifo: AVG_LOG2 must be in 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // eoc rising-edge detect. eoc_q resets high so that an eoc already
    // asserted when reset releases is not mistaken for a new conversion.
    // ------------------------------------------------------------------
    logic eoc_q;
    logic cap;

    // Delay eoc by one cycle for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) eoc_q <= 1'b1;
        else        eoc_q <= bus.eoc;
    end

    assign cap = bus.eoc & ~eoc_q;

    // ------------------------------------------------------------------
    // Result path: either direct, or block average of 2^AVG_LOG2 codes.
    // ------------------------------------------------------------------
    logic              push;
    logic [DATA_W-1:0] push_data;

`ifdef SAR_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] cnt;
    logic [ACC_W-1:0]    sum;
    logic                last;

    // Accumulator never overflows: 2^AVG_LOG2 samples of DATA_W bits fit.
    assign sum       = acc + ACC_W'(bus.sar_in);
    assign last      = (cnt == {AVG_LOG2{1'b1}});
    assign push      = cap & last;
    assign push_data = DATA_W'(sum >> AVG_LOG2);

    // Accumulate samples; restart on the block's final sample or on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (bus.clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (cap) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + AVG_LOG2'(1);
            end
        end
    end
`else
    assign push      = cap;
    assign push_data = bus.sar_in;
`endif

    // ------------------------------------------------------------------
    // Circular FIFO. Pointers wrap naturally since DEPTH is a power of two.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic              valid;
    logic              full;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    assign valid  = (fill != '0);
    assign full   = (fill == FILL_W'(DEPTH));
    // Pop only when data exists, so ready while empty is ignored.
    assign do_pop = valid & bus.dout_ready;
    // A full FIFO still accepts a push if the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Storage write; contents are not reset and a clr cycle writes nothing.
    always_ff @(posedge clk) begin
        if (do_push && !bus.clr) mem[wr_ptr] <= push_data;
    end

    // Pointer, occupancy and overflow bookkeeping; clr beats everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    assign bus.dout       = mem[rd_ptr];
    assign bus.dout_valid = valid;
    assign bus.fill       = fill;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_sar_result_fifo.sv
// Directed bench for sar_result_fifo (DATA_W=8, DEPTH=8, AVG_LOG2=2).
// Averaging expectations are selected by SAR_AVG_EN so the bench matches
// whichever build it is compiled with.
module tb_sar_result_fifo;
    logic clk;
    logic rst_n;

    sar_result_fifo_if #(.DATA_W(8), .DEPTH(8)) bus ();

    sar_result_fifo #(.DATA_W(8), .DEPTH(8), .AVG_LOG2(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and
    // outputs are sampled here, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        bus.sar_in = v;
        bus.eoc    = 1'b1;
        tick();
        bus.eoc    = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    logic [7:0] exp_q [8];

    initial begin
        rst_n          = 1'b0;
        bus.sar_in     = '0;
        bus.eoc        = 1'b0;
        bus.clr        = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        chk("rst_fill",  32'(bus.fill), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_ovf",   32'(bus.overflow), 0);
        rst_n = 1'b1;
        tick();

`ifndef SAR_AVG_EN
        // Single capture: visible one cycle after eoc seen high.
        bus.sar_in = 8'hA5;
        bus.eoc    = 1'b1;
        tick();
        chk("single_valid", 32'(bus.dout_valid), 1);
        chk("single_dout",  32'(bus.dout), 32'hA5);
        chk("single_fill",  32'(bus.fill), 1);
        bus.eoc = 1'b0;
        tick();
        do_clr();
        chk("clr_fill", 32'(bus.fill), 0);

        // Overrun: 10 pushes into 8 entries.
        for (int i = 1; i <= 10; i++) pulse(8'(i));
        chk("ovr_fill", 32'(bus.fill), 8);
        chk("ovr_flag", 32'(bus.overflow), 1);
        bus.dout_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_dout", 32'(bus.dout), 32'(i));
            tick();
        end
        bus.dout_ready = 1'b0;
        chk("drain_empty", 32'(bus.dout_valid), 0);
        chk("drain_ovf_sticky", 32'(bus.overflow), 1);
        do_clr();
        chk("clr_ovf", 32'(bus.overflow), 0);

        // Long eoc: one capture only.
        bus.sar_in = 8'h3C;
        bus.eoc    = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.eoc = 1'b0;
        tick();
        chk("long_eoc_fill", 32'(bus.fill), 1);
        chk("long_eoc_dout", 32'(bus.dout), 32'h3C);
        do_clr();

        // eoc high across reset release: no capture.
        rst_n   = 1'b0;
        bus.eoc = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("eoc_rst_fill", 32'(bus.fill), 0);
        bus.eoc = 1'b0;
        tick();

        // Full + pop + coincident capture: both occur, new word goes last.
        for (int i = 0; i < 8; i++) pulse(8'(8'h10 + i));
        chk("full_fill", 32'(bus.fill), 8);
        bus.dout_ready = 1'b1;
        bus.sar_in     = 8'h99;
        bus.eoc        = 1'b1;
        tick();
        bus.eoc        = 1'b0;
        bus.dout_ready = 1'b0;
        chk("pp_fill", 32'(bus.fill), 8);
        chk("pp_ovf",  32'(bus.overflow), 0);
        chk("pp_head", 32'(bus.dout), 32'h11);
        for (int i = 0; i < 7; i++) exp_q[i] = 8'(8'h11 + i);
        exp_q[7] = 8'h99;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain", 32'(bus.dout), 32'(exp_q[i]));
            tick();
        end
        bus.dout_ready = 1'b0;
        chk("pp_empty", 32'(bus.dout_valid), 0);

        // clr coincident with eoc rise: nothing captured.
        pulse(8'h42);
        bus.clr    = 1'b1;
        bus.sar_in = 8'h55;
        bus.eoc    = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_cap_fill", 32'(bus.fill), 0);
        tick();
        bus.eoc = 1'b0;
        tick();
        chk("clr_cap_fill2",  32'(bus.fill), 0);
        chk("clr_cap_valid",  32'(bus.dout_valid), 0);

        // Asynchronous reset with fill=5 and overflow set.
        for (int i = 0; i < 9; i++) pulse(8'(i));
        bus.dout_ready = 1'b1;
        tick(); tick(); tick();
        bus.dout_ready = 1'b0;
        chk("pre_rst_fill", 32'(bus.fill), 5);
        chk("pre_rst_ovf",  32'(bus.overflow), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_fill",  32'(bus.fill), 0);
        chk("arst_valid", 32'(bus.dout_valid), 0);
        chk("arst_ovf",   32'(bus.overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse(8'd4); pulse(8'd8); pulse(8'd12); pulse(8'd16);
        chk("post_rst_fill", 32'(bus.fill), 4);
        chk("post_rst_dout", 32'(bus.dout), 4);
`else
        // Averaging: 10,11,12,14 -> 47>>2 = 11, ready one cycle after 4th eoc.
        pulse(8'd10); pulse(8'd11); pulse(8'd12);
        chk("avg_partial_fill", 32'(bus.fill), 0);
        bus.sar_in = 8'd14;
        bus.eoc    = 1'b1;
        tick();
        chk("avg_valid", 32'(bus.dout_valid), 1);
        chk("avg_dout",  32'(bus.dout), 11);
        chk("avg_fill",  32'(bus.fill), 1);
        bus.eoc = 1'b0;
        tick();
        do_clr();

        // Max code: 255 x 4 -> 255.
        for (int i = 0; i < 4; i++) pulse(8'd255);
        chk("avg_max_dout", 32'(bus.dout), 255);
        chk("avg_max_fill", 32'(bus.fill), 1);
        do_clr();

        // Long eoc counts as one sample: 3 pulses + long eoc of 20 completes block.
        pulse(8'd1); pulse(8'd2); pulse(8'd3);
        bus.sar_in = 8'd6;
        bus.eoc    = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.eoc = 1'b0;
        tick();
        chk("avg_long_fill", 32'(bus.fill), 1);
        chk("avg_long_dout", 32'(bus.dout), 3);
        do_clr();

        // clr mid-block discards accumulated samples.
        pulse(8'd200); pulse(8'd200);
        do_clr();
        for (int i = 0; i < 4; i++) pulse(8'd8);
        chk("avg_clr_dout", 32'(bus.dout), 8);
        do_clr();

        // Async reset with fill=5 and a partial block.
        for (int i = 0; i < 22; i++) pulse(8'd20);
        chk("pre_rst_fill", 32'(bus.fill), 5);
        rst_n = 1'b0;
        #1;
        chk("arst_fill",  32'(bus.fill), 0);
        chk("arst_valid", 32'(bus.dout_valid), 0);
        chk("arst_ovf",   32'(bus.overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse(8'd4); pulse(8'd8); pulse(8'd12);
        chk("post_rst_partial", 32'(bus.fill), 0);
        pulse(8'd16);
        chk("post_rst_fill", 32'(bus.fill), 1);
        chk("post_rst_dout", 32'(bus.dout), 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
